// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Shares one spi_master between NUM_REQ requesters. A round-robin arbiter
// grants the bus for a whole packet, drives that requester's active-low chip
// select, loads its SPI mode / prescaller / bit order into the spi_master,
// performs the wr and rd strobe handshakes and hands every received word back
// to the owning requester.
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   req_valid/last/data per-requester byte stream (slice i = requester i)
//   req_ready           one-cycle accept pulse per requester
//   rsp_valid/rsp_data  one-cycle receive pulse per requester, shared data
//   cfg_mode/presc/lsb  per-requester SPI configuration, sampled at grant
//   cs_n                per-requester chip select, at most one bit low
//   busy                a packet is in progress
//   timeout_err/err_clr sticky receive-timeout flag and its clear
//   m_*                 connection to the attached spi_master
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WORD_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*WORD_LEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [WORD_LEN-1:0]          rsp_data,
  input  logic [NUM_REQ*2-1:0]         cfg_mode,
  input  logic [NUM_REQ*3-1:0]         cfg_presc,
  input  logic [NUM_REQ-1:0]           cfg_lsb,
  output logic [NUM_REQ-1:0]           cs_n,
  output logic                         busy,
  output logic                         timeout_err,
  input  logic                         err_clr,
  output logic [WORD_LEN-1:0]          m_data_in,
  output logic                         m_wr,
  output logic                         m_rd,
  input  logic [WORD_LEN-1:0]          m_data_out,
  input  logic                         m_charreceived,
  output logic [1:0]                   m_mode,
  output logic [2:0]                   m_prescaller,
  output logic                         m_lsbfirst
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_SETUP, S_WR, S_WAIT_RX, S_RD, S_CAPTURE, S_RELEASE
  } state_e;

  state_e              state_q;
  logic [PW-1:0]       ptr_q, gnt_q;
  logic                last_q;
  logic                phase_q;          // first/second cycle of WR and RD
  logic [TO_W-1:0]     to_cnt_q;
  logic [1:0]          sync_q;
  logic                charreceived_s;

  logic [NUM_REQ-1:0]  cs_n_q, req_ready_q, rsp_valid_q;
  logic [WORD_LEN-1:0] rsp_data_q, m_data_in_q;
  logic                busy_q, timeout_err_q, m_wr_q, m_rd_q, m_lsb_q;
  logic [1:0]          m_mode_q;
  logic [2:0]          m_presc_q;

  // Per-requester views of the flattened input buses.
  logic [WORD_LEN-1:0] data_arr  [NUM_REQ];
  logic [1:0]          mode_arr  [NUM_REQ];
  logic [2:0]          presc_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign data_arr[g]  = req_data[g*WORD_LEN +: WORD_LEN];
    assign mode_arr[g]  = cfg_mode[g*2 +: 2];
    assign presc_arr[g] = cfg_presc[g*3 +: 3];
  end

  assign charreceived_s = sync_q[1];

  // Round-robin winner: first valid requester at or above ptr_q, wrapping.
  logic [PW-1:0] gnt_d;
  logic          gnt_found;

  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    int unsigned   idx_int;
    logic [PW-1:0] idx;
    gnt_d     = '0;
    gnt_found = 1'b0;
    idx_int   = 0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_int = (int'(ptr_q) + k) % NUM_REQ;
      idx     = PW'(idx_int);
      if (!gnt_found && req_valid[idx]) begin
        gnt_d     = idx;
        gnt_found = 1'b1;
      end
    end
  end

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      last_q        <= 1'b0;
      phase_q       <= 1'b0;
      to_cnt_q      <= '0;
      sync_q        <= '0;
      cs_n_q        <= '1;
      busy_q        <= 1'b0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      timeout_err_q <= 1'b0;
      m_data_in_q   <= '0;
      m_wr_q        <= 1'b0;
      m_rd_q        <= 1'b0;
      m_mode_q      <= '0;
      m_presc_q     <= '0;
      m_lsb_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], m_charreceived};
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      // A timeout set later in this block overrides a simultaneous clear.
      if (err_clr) timeout_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            gnt_q     <= gnt_d;
            m_mode_q  <= mode_arr[gnt_d];
            m_presc_q <= presc_arr[gnt_d];
            m_lsb_q   <= cfg_lsb[gnt_d];
            state_q   <= S_GRANT;
          end
        end
        S_GRANT: begin
          cs_n_q  <= ~(NUM_REQ'(1) << gnt_q);
          busy_q  <= 1'b1;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          if (req_valid[gnt_q]) begin
            m_data_in_q        <= data_arr[gnt_q];
            req_ready_q[gnt_q] <= 1'b1;
            last_q             <= req_last[gnt_q];
            phase_q            <= 1'b0;
            state_q            <= S_WR;
          end
        end
        S_WR: begin
          // m_wr is seen high in the second WR cycle and first WAIT_RX cycle.
          m_wr_q  <= 1'b1;
          phase_q <= 1'b1;
          if (phase_q) begin
            to_cnt_q <= '0;
            state_q  <= S_WAIT_RX;
          end
        end
        S_WAIT_RX: begin
          m_wr_q <= 1'b0;
          if (charreceived_s) begin
            phase_q <= 1'b0;
            state_q <= S_RD;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_RELEASE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_RD: begin
          m_rd_q  <= 1'b1;
          phase_q <= 1'b1;
          if (phase_q) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // m_rd is still high here, so m_data_out is the received word.
          rsp_data_q         <= m_data_out;
          rsp_valid_q[gnt_q] <= 1'b1;
          m_rd_q             <= 1'b0;
          state_q            <= last_q ? S_RELEASE : S_SETUP;
        end
        S_RELEASE: begin
          cs_n_q  <= '1;
          busy_q  <= 1'b0;
          ptr_q   <= (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign cs_n         = cs_n_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign m_data_in    = m_data_in_q;
  assign m_wr         = m_wr_q;
  assign m_rd         = m_rd_q;
  assign m_mode       = m_mode_q;
  assign m_prescaller = m_presc_q;
  assign m_lsbfirst   = m_lsb_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Directed bench for spi_master_arbiter (4 requesters, 8-bit words, 16-cycle
// receive timeout). A small spi_master stand-in answers every written byte
// with byte ^ 8'h99 a few cycles later; a monitor logs grants, responses and
// strobe widths, and one task per scenario compares against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_spi_master_arbiter;

  localparam int NR = 4;
  localparam int WL = 8;
  localparam int TO = 16;
  localparam int TW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_last  = '0;
  logic [NR*WL-1:0]  req_data  = '0;
  logic [NR-1:0]     req_ready, rsp_valid, cs_n;
  logic [WL-1:0]     rsp_data, m_data_in;
  logic [NR*2-1:0]   cfg_mode  = '0;
  logic [NR*3-1:0]   cfg_presc = '0;
  logic [NR-1:0]     cfg_lsb   = '0;
  logic              busy, timeout_err, m_wr, m_rd, m_lsbfirst;
  logic              err_clr = 1'b0;
  logic [WL-1:0]     m_data_out = '0;
  logic              m_charreceived = 1'b0;
  logic [1:0]        m_mode;
  logic [2:0]        m_prescaller;

  int tests_run = 0;
  int failed    = 0;

  spi_master_arbiter #(
    .NUM_REQ(NR), .WORD_LEN(WL), .TIMEOUT_CYCLES(TO), .TO_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cfg_mode(cfg_mode), .cfg_presc(cfg_presc), .cfg_lsb(cfg_lsb),
    .cs_n(cs_n), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
    .m_data_in(m_data_in), .m_wr(m_wr), .m_rd(m_rd),
    .m_data_out(m_data_out), .m_charreceived(m_charreceived),
    .m_mode(m_mode), .m_prescaller(m_prescaller), .m_lsbfirst(m_lsbfirst)
  );

  initial forever #5 clk = ~clk;

  // ---------------------------------------------------------------- spi model
  logic       stall = 1'b0;     // emulates a spi_master held in reset
  logic       wr_d  = 1'b0;
  int         xfer_cnt = 0;
  logic [7:0] echo_q = '0;

  always @(posedge clk) begin
    wr_d <= m_wr;
    if (m_rd) m_charreceived <= 1'b0;
    if (m_wr && !wr_d && !stall) begin
      xfer_cnt <= 4;
      echo_q   <= m_data_in ^ 8'h99;
    end else if (xfer_cnt != 0) begin
      xfer_cnt <= xfer_cnt - 1;
      if (xfer_cnt == 1) begin
        m_charreceived <= 1'b1;
        m_data_out     <= echo_q;
      end
    end
  end

  // ---------------------------------------------------------------- requesters
  logic [7:0] pkt_data [NR][8];
  int         pkt_len  [NR];
  int         pkt_pos  [NR];

  task automatic drive_req();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (pkt_pos[i] < pkt_len[i]);
      req_last[i]           = (pkt_pos[i] == pkt_len[i] - 1);
      req_data[i*WL +: WL]  = (pkt_pos[i] < pkt_len[i]) ? pkt_data[i][pkt_pos[i]] : 8'h00;
    end
  endtask

  task automatic load_pkt(input int i, input int n,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    pkt_data[i][0] = b0;
    pkt_data[i][1] = b1;
    pkt_data[i][2] = b2;
    pkt_pos[i]     = 0;
    pkt_len[i]     = n;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      pkt_len[i] = 0;
      pkt_pos[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (req_ready[i] && pkt_pos[i] < pkt_len[i]) pkt_pos[i]++;
      drive_req();
    end
  end

  // ---------------------------------------------------------------- monitor
  int         cyc = 0;
  int         grant_n = 0, rsp_n = 0;
  int         grant_log [64];
  logic [1:0] grant_mode [64];
  logic [2:0] grant_presc [64];
  logic       grant_lsb [64];
  int         rsp_idx [64];
  logic [7:0] rsp_dat [64];
  int         ready_cnt [NR];
  int         cs_multi = 0, cs_change = 0, foreign = 0, gap = 100, gap_bad = 0;
  int         wr_run = 0, wr_runs_n = 0, wr_bad = 0, wr_fall_cyc = 0;
  int         rd_run = 0, rd_bad = 0;
  int         err_rise_cyc = 0;
  logic       err_prev = 1'b0;
  logic [NR-1:0] cs_prev = '1;

  function automatic int low_idx(input logic [NR-1:0] c);
    for (int i = 0; i < NR; i++) if (!c[i]) return i;
    return -1;
  endfunction

  initial for (int i = 0; i < NR; i++) ready_cnt[i] = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if ($countones(~cs_n) > 1) cs_multi = cs_multi + 1;
    if (cs_prev == '1 && cs_n != '1 && grant_n < 64) begin
      grant_log[grant_n]   = low_idx(cs_n);
      grant_mode[grant_n]  = m_mode;
      grant_presc[grant_n] = m_prescaller;
      grant_lsb[grant_n]   = m_lsbfirst;
      grant_n = grant_n + 1;
      if (gap < 2) gap_bad = gap_bad + 1;
    end
    if (cs_prev != '1 && cs_n != '1 && cs_n != cs_prev) cs_change = cs_change + 1;
    gap = (cs_n == '1) ? gap + 1 : 0;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) ready_cnt[i] = ready_cnt[i] + 1;
      if ((req_ready[i] || rsp_valid[i]) && cs_n[i]) foreign = foreign + 1;
      if (rsp_valid[i] && rsp_n < 64) begin
        rsp_idx[rsp_n] = i;
        rsp_dat[rsp_n] = rsp_data;
        rsp_n = rsp_n + 1;
      end
    end
    if (m_wr) wr_run = wr_run + 1;
    else if (wr_run != 0) begin
      wr_runs_n   = wr_runs_n + 1;
      if (wr_run != 2) wr_bad = wr_bad + 1;
      wr_run      = 0;
      wr_fall_cyc = cyc;
    end
    if (m_rd) rd_run = rd_run + 1;
    else if (rd_run != 0) begin
      if (rd_run != 2) rd_bad = rd_bad + 1;
      rd_run = 0;
    end
    if (timeout_err && !err_prev) err_rise_cyc = cyc;
    err_prev = timeout_err;
    cs_prev  = cs_n;
  end

  // ---------------------------------------------------------------- helpers
  task automatic wait_done(input int g, input int r, input string name);
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (grant_n >= g && rsp_n >= r && cs_n == '1 && !busy) done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      failed++;
      $display("FAIL %s: completion not seen (grants %0d need %0d, rsp %0d need %0d)",
               name, grant_n, g, rsp_n, r);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #1 rst = 1'b0;
    #3;
    tests_run++;
    if (cs_n !== 4'b1111) begin failed++; $display("FAIL reset_cs_n: got %b want 1111", cs_n); end
    tests_run++;
    if ({busy, timeout_err, m_wr, m_rd} !== 4'b0000) begin
      failed++; $display("FAIL reset_flags: got %b want 0000", {busy, timeout_err, m_wr, m_rd});
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, rsp_valid, rsp_data, m_data_in} !== '0) begin
      failed++; $display("FAIL reset_data: got %h want 0", {req_ready, rsp_valid, rsp_data, m_data_in});
    end
    tests_run++;
    if ({m_mode, m_prescaller, m_lsbfirst} !== 6'b0) begin
      failed++; $display("FAIL reset_cfg: got %b want 000000", {m_mode, m_prescaller, m_lsbfirst});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int g0, r0, rdy0, wn0;
    g0 = grant_n; r0 = rsp_n; rdy0 = ready_cnt[0]; wn0 = wr_runs_n;
    load_pkt(0, 1, 8'hA5, 8'h00, 8'h00);
    wait_done(g0 + 1, r0 + 1, "single_done");
    tests_run++;
    if (grant_log[g0] !== 0) begin failed++; $display("FAIL single_grant: got %0d want 0", grant_log[g0]); end
    tests_run++;
    if (ready_cnt[0] - rdy0 !== 1) begin
      failed++; $display("FAIL single_ready: got %0d pulses want 1", ready_cnt[0] - rdy0);
    end
    tests_run++;
    if (wr_runs_n - wn0 !== 1 || wr_bad !== 0) begin
      failed++; $display("FAIL single_wr: got %0d runs, %0d bad widths, want 1 run of 2", wr_runs_n - wn0, wr_bad);
    end
    tests_run++;
    if (rsp_idx[r0] !== 0 || rsp_dat[r0] !== 8'h3C) begin
      failed++; $display("FAIL single_rsp: got req %0d data %h want req 0 data 3c", rsp_idx[r0], rsp_dat[r0]);
    end
    tests_run++;
    if (cs_n !== 4'b1111 || cs_change !== 0) begin
      failed++; $display("FAIL single_cs: got %b (%0d changes) want 1111, 0 changes", cs_n, cs_change);
    end
  endtask

  task automatic test_burst();
    int g0, r0, rdy0;
    g0 = grant_n; r0 = rsp_n; rdy0 = ready_cnt[2];
    load_pkt(2, 3, 8'h01, 8'h02, 8'h03);
    wait_done(g0 + 1, r0 + 3, "burst_done");
    tests_run++;
    if (grant_n - g0 !== 1 || grant_log[g0] !== 2) begin
      failed++; $display("FAIL burst_grant: got %0d grants first %0d want 1 grant of 2", grant_n - g0, grant_log[g0]);
    end
    tests_run++;
    if (ready_cnt[2] - rdy0 !== 3) begin
      failed++; $display("FAIL burst_ready: got %0d want 3", ready_cnt[2] - rdy0);
    end
    tests_run++;
    if ({rsp_dat[r0], rsp_dat[r0+1], rsp_dat[r0+2]} !== 24'h989B9A) begin
      failed++; $display("FAIL burst_data: got %h%h%h want 989b9a", rsp_dat[r0], rsp_dat[r0+1], rsp_dat[r0+2]);
    end
    tests_run++;
    if (rsp_idx[r0] !== 2 || rsp_idx[r0+1] !== 2 || rsp_idx[r0+2] !== 2 || cs_change !== 0 || rd_bad !== 0) begin
      failed++; $display("FAIL burst_owner: got idx %0d %0d %0d cs changes %0d rd bad %0d want 2 2 2 0 0",
                         rsp_idx[r0], rsp_idx[r0+1], rsp_idx[r0+2], cs_change, rd_bad);
    end
  endtask

  task automatic test_round_robin();
    int g0, r0;
    do_reset();
    g0 = grant_n; r0 = rsp_n;
    load_pkt(0, 1, 8'h10, 8'h00, 8'h00);
    load_pkt(1, 1, 8'h20, 8'h00, 8'h00);
    load_pkt(2, 1, 8'h30, 8'h00, 8'h00);
    load_pkt(3, 1, 8'h40, 8'h00, 8'h00);
    wait_done(g0 + 4, r0 + 4, "rr_first_done");
    tests_run++;
    if ({grant_log[g0], grant_log[g0+1], grant_log[g0+2], grant_log[g0+3]} !== {32'd0, 32'd1, 32'd2, 32'd3}) begin
      failed++; $display("FAIL rr_order: got %0d %0d %0d %0d want 0 1 2 3",
                         grant_log[g0], grant_log[g0+1], grant_log[g0+2], grant_log[g0+3]);
    end
    tests_run++;
    if ({rsp_dat[r0], rsp_dat[r0+1], rsp_dat[r0+2], rsp_dat[r0+3]} !== 32'h89B9A9D9) begin
      failed++; $display("FAIL rr_data: got %h %h %h %h want 89 b9 a9 d9",
                         rsp_dat[r0], rsp_dat[r0+1], rsp_dat[r0+2], rsp_dat[r0+3]);
    end
    load_pkt(0, 1, 8'h55, 8'h00, 8'h00);
    load_pkt(3, 1, 8'h66, 8'h00, 8'h00);
    wait_done(g0 + 6, r0 + 6, "rr_second_done");
    tests_run++;
    if (grant_log[g0+4] !== 0 || grant_log[g0+5] !== 3) begin
      failed++; $display("FAIL rr_reorder: got %0d %0d want 0 3", grant_log[g0+4], grant_log[g0+5]);
    end
    tests_run++;
    if (cs_multi !== 0 || foreign !== 0 || gap_bad !== 0) begin
      failed++; $display("FAIL rr_exclusive: got multi %0d foreign %0d gap %0d want 0 0 0", cs_multi, foreign, gap_bad);
    end
  endtask

  task automatic test_config();
    int g0, r0;
    cfg_mode  = {2'd2, 2'd1, 2'd3, 2'd0};
    cfg_presc = {3'd7, 3'd6, 3'd4, 3'd1};
    cfg_lsb   = 4'b0010;
    g0 = grant_n; r0 = rsp_n;
    load_pkt(0, 1, 8'h0F, 8'h00, 8'h00);
    load_pkt(1, 1, 8'hF0, 8'h00, 8'h00);
    wait_done(g0 + 2, r0 + 2, "cfg_done");
    tests_run++;
    if (grant_log[g0] !== 0 || {grant_mode[g0], grant_presc[g0], grant_lsb[g0]} !== {2'd0, 3'd1, 1'b0}) begin
      failed++; $display("FAIL cfg_req0: got req %0d mode %0d presc %0d lsb %0d want 0 0 1 0",
                         grant_log[g0], grant_mode[g0], grant_presc[g0], grant_lsb[g0]);
    end
    tests_run++;
    if (grant_log[g0+1] !== 1 || {grant_mode[g0+1], grant_presc[g0+1], grant_lsb[g0+1]} !== {2'd3, 3'd4, 1'b1}) begin
      failed++; $display("FAIL cfg_req1: got req %0d mode %0d presc %0d lsb %0d want 1 3 4 1",
                         grant_log[g0+1], grant_mode[g0+1], grant_presc[g0+1], grant_lsb[g0+1]);
    end
  endtask

  task automatic test_timeout();
    int g0, r0;
    stall = 1'b1;
    g0 = grant_n; r0 = rsp_n;
    load_pkt(1, 1, 8'h77, 8'h00, 8'h00);
    wait_done(g0 + 1, r0, "to_done");
    tests_run++;
    if (timeout_err !== 1'b1 || cs_n !== 4'b1111) begin
      failed++; $display("FAIL to_flag: got err %b cs_n %b want 1 1111", timeout_err, cs_n);
    end
    // m_wr is seen low from the 2nd WAIT_RX cycle; the flag appears after the 16th.
    tests_run++;
    if (err_rise_cyc - wr_fall_cyc !== TO - 1) begin
      failed++; $display("FAIL to_cycles: got %0d want %0d", err_rise_cyc - wr_fall_cyc, TO - 1);
    end
    tests_run++;
    if (rsp_n !== r0) begin failed++; $display("FAIL to_no_rsp: got %0d responses want 0", rsp_n - r0); end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    tests_run++;
    if (timeout_err !== 1'b0) begin failed++; $display("FAIL to_clear: got %b want 0", timeout_err); end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    int g0, r0, f0;
    bit seen = 1'b0;
    stall = 1'b1;
    g0 = grant_n; r0 = rsp_n; f0 = wr_fall_cyc;
    load_pkt(2, 1, 8'h44, 8'h00, 8'h00);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (wr_fall_cyc != f0) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (!seen || cs_n !== 4'b1011 || busy !== 1'b1) begin
      failed++; $display("FAIL rstmid_wait: got seen %b cs_n %b busy %b want 1 1011 1", seen, cs_n, busy);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({cs_n, m_wr, m_rd, busy} !== 7'b1111_000) begin
      failed++; $display("FAIL rstmid_async: got %b want 1111000", {cs_n, m_wr, m_rd, busy});
    end
    for (int i = 0; i < NR; i++) begin
      pkt_len[i] = 0;
      pkt_pos[i] = 0;
    end
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    tests_run++;
    if (rsp_n !== r0 || timeout_err !== 1'b0) begin
      failed++; $display("FAIL rstmid_abort: got %0d rsp err %b want 0 0", rsp_n - r0, timeout_err);
    end
    g0 = grant_n;
    load_pkt(3, 1, 8'h12, 8'h00, 8'h00);
    load_pkt(0, 1, 8'h34, 8'h00, 8'h00);
    wait_done(g0 + 2, r0 + 2, "rstmid_done");
    tests_run++;
    if (grant_log[g0] !== 0 || grant_log[g0+1] !== 3) begin
      failed++; $display("FAIL rstmid_ptr: got %0d %0d want 0 3", grant_log[g0], grant_log[g0+1]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_round_robin();
    test_config();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
